// File: rtl/freq_div_prog.sv
// Programmable frequency divider and timebase: divided square clock, tick strobe,
// glitch-free divisor reload at period boundaries, and a free-running scan-control bus.
module freq_div_prog #(
    parameter int          CNT_W       = 27,
    parameter int unsigned DIV_DEFAULT = 67108863,
    parameter int          SCAN_TAP    = 15,
    parameter int          SCAN_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              div_load,
    output logic              clk_out,
    output logic              tick,
    output logic [SCAN_W-1:0] clk_ctl,
    output logic              load_pend
);

    localparam int PRE_W = SCAN_TAP + SCAN_W;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic [PRE_W-1:0] prescaler;
    logic             term;

    // cnt never exceeds div_act, so the increment cannot wrap even at all-ones
    assign term    = en && (cnt == div_act);
    assign clk_ctl = prescaler[PRE_W-1:SCAN_TAP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            prescaler <= '0;
            div_act   <= DIV_RST;
            div_shd   <= DIV_RST;
            load_pend <= 1'b0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);

            if (term) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                if (en) begin
                    cnt <= cnt + CNT_W'(1);
                end
                tick <= 1'b0;
            end

            // div_act only moves on a terminal event, so every phase is whole
            if (term) begin
                if (div_load) begin
                    div_act   <= div_val;
                    div_shd   <= div_val;
                    load_pend <= 1'b0;
                end else if (load_pend) begin
                    div_act   <= div_shd;
                    load_pend <= 1'b0;
                end
            end else if (div_load) begin
                div_shd   <= div_val;
                load_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog (CNT_W=8, DIV_DEFAULT=3, SCAN_TAP=2, SCAN_W=2).
module tb_freq_div_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic [1:0] clk_ctl;
    logic       load_pend;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    freq_div_prog #(
        .CNT_W      (8),
        .DIV_DEFAULT(3),
        .SCAN_TAP   (2),
        .SCAN_W     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .clk_ctl  (clk_ctl),
        .load_pend(load_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        div_val  = 8'd0;
        div_load = 1'b0;
        #12;
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_clk_ctl", 32'(clk_ctl), 0);
        check("rst_load_pend", 32'(load_pend), 0);
        rst_n = 1'b1;
        cyc   = 0;

        // default divisor 3: tick every 4, clk_out period 8, clk_ctl steps every 4
        for (int k = 1; k <= 16; k++) begin
            step();
            check("t1_tick", 32'(tick), 32'(cyc % 4 == 0));
            check("t1_clk_out", 32'(clk_out), (cyc / 4) % 2);
            check("t1_clk_ctl", 32'(clk_ctl), (cyc / 4) % 4);
            check("t1_load_pend", 32'(load_pend), 0);
        end

        // load 9 while cnt=1: current period ends normally, then 10-cycle periods
        step();
        div_val  = 8'd9;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("t2_pend_set", 32'(load_pend), 1);
        check("t2_tick_18", 32'(tick), 0);
        for (int k = 19; k <= 40; k++) begin
            step();
            check("t2_tick", 32'(tick), 32'(cyc == 20 || cyc == 30 || cyc == 40));
            check("t2_load_pend", 32'(load_pend), 32'(cyc < 20));
            check("t2_clk_out", 32'(clk_out), 32'((cyc >= 20 && cyc < 30) || cyc == 40));
        end

        // load 0 coincident with the term: immediate effect, tick stays high
        for (int k = 41; k <= 49; k++) begin
            step();
            check("t3_tick_pre", 32'(tick), 0);
        end
        div_val  = 8'd0;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("t3_tick_50", 32'(tick), 1);
        check("t3_clk_out_50", 32'(clk_out), 0);
        check("t3_pend_50", 32'(load_pend), 0);
        for (int k = 51; k <= 57; k++) begin
            step();
            check("t3_tick", 32'(tick), 1);
            check("t3_clk_out", 32'(clk_out), cyc % 2);
            check("t3_load_pend", 32'(load_pend), 0);
        end

        // restore divisor 3, then freeze at cnt=2 for 5 cycles
        div_val  = 8'd3;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("t4_tick_58", 32'(tick), 1);
        check("t4_clk_out_58", 32'(clk_out), 0);
        check("t4_pend_58", 32'(load_pend), 0);
        step();
        step();
        en = 1'b0;
        for (int k = 61; k <= 65; k++) begin
            step();
            check("t4_frz_tick", 32'(tick), 0);
            check("t4_frz_clk_out", 32'(clk_out), 0);
            check("t4_frz_clk_ctl", 32'(clk_ctl), (cyc / 4) % 4);
        end
        en = 1'b1;
        step();
        check("t4_tick_66", 32'(tick), 0);
        step();
        check("t4_tick_67", 32'(tick), 1);
        check("t4_clk_out_67", 32'(clk_out), 1);

        // loads 5 then 7 back to back: 7 wins at the next term
        step();
        div_val  = 8'd5;
        div_load = 1'b1;
        step();
        check("t5_pend_69", 32'(load_pend), 1);
        div_val = 8'd7;
        step();
        div_load = 1'b0;
        check("t5_pend_70", 32'(load_pend), 1);
        check("t5_tick_70", 32'(tick), 0);
        for (int k = 71; k <= 87; k++) begin
            step();
            check("t5_tick", 32'(tick), 32'(cyc == 71 || cyc == 79 || cyc == 87));
            check("t5_load_pend", 32'(load_pend), 0);
            check("t5_clk_out", 32'(clk_out), 32'(cyc >= 79 && cyc < 87));
        end

        // async reset mid-period with a load pending
        for (int k = 88; k <= 95; k++) step();
        check("t6_tick_95", 32'(tick), 1);
        check("t6_clk_out_95", 32'(clk_out), 1);
        step();
        div_val  = 8'd20;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("t6_pend_97", 32'(load_pend), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_clk_out", 32'(clk_out), 0);
        check("t6_rst_tick", 32'(tick), 0);
        check("t6_rst_load_pend", 32'(load_pend), 0);
        check("t6_rst_clk_ctl", 32'(clk_ctl), 0);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t6_tick", 32'(tick), 32'(cyc % 4 == 0));
            check("t6_clk_out", 32'(clk_out), 32'(cyc >= 4 && cyc < 8));
            check("t6_load_pend", 32'(load_pend), 0);
            check("t6_clk_ctl", 32'(clk_ctl), (cyc / 4) % 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
